// File: rtl/fiber_map_pkg.sv
// Shared constants, header layout and FSM encoding for the fibre-hit mapper.
package fiber_map_pkg;

    localparam logic [15:0] SYNC_WORD = 16'hAAAA;
    localparam int CNT_W = 16;

    // Hit word layout inside one 16-bit channel slot
    localparam int HIT_VALID_BIT = 12;
    localparam int X_MSB = 11;
    localparam int X_LSB = 6;
    localparam int Y_MSB = 5;
    localparam int Y_LSB = 0;

    // Frame header layout
    localparam int HDR_W        = 38;
    localparam int HDR_FLAG_BIT = 37;
    localparam int HDR_CODE_MSB = 36;
    localparam int HDR_CODE_LSB = 26;
    localparam int HDR_TAG_MSB  = 25;
    localparam int HDR_TAG_LSB  = 16;
    localparam int HDR_SYNC_MSB = 15;
    localparam int HDR_SYNC_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_EMIT
    } state_e;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fiber_hit_decode.sv
// Per-channel hit decode: turns one hit word into window row/column and an
// accept or out-of-range flag.
module fiber_hit_decode
    import fiber_map_pkg::*;
#(
    parameter int ROW_LO = 14,
    parameter int NROWS  = 10,
    parameter int COLS   = 38,
    parameter int RW     = 4,
    parameter int CW     = 6
) (
    input  logic [15:0]   ch,
    input  logic          en,
    output logic          accept,
    output logic          oor,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col
);

    logic [6:0] x;
    logic [6:0] y;
    logic       valid;
    logic       in_win;
    logic       unused_tag_bits;

    assign unused_tag_bits = ^ch[15:13];

    // 7-bit arithmetic so a field of 63 becomes 64 rather than wrapping to 0
    assign x = {1'b0, ch[X_MSB:X_LSB]} + 7'd1;
    assign y = {1'b0, ch[Y_MSB:Y_LSB]} + 7'd1;

    assign valid  = en & ch[HIT_VALID_BIT];
    assign in_win = (y >= 7'(ROW_LO)) && (y <= 7'(ROW_LO + NROWS - 1))
                    && (x <= 7'(COLS - 1));

    assign accept = valid & in_win;
    assign oor    = valid & ~in_win;
    assign row    = RW'(y - 7'(ROW_LO));
    assign col    = CW'(x);

endmodule

// File: rtl/fiber_hit_mapper.sv
// Accumulates NCH channels of fibre hits over NFRAME beats after a sync word
// into a row-bitmap window and emits it as a one-cycle frame with counters.
module fiber_hit_mapper
    import fiber_map_pkg::*;
#(
    parameter int          NCH      = 16,
    parameter int          NFRAME   = 16,
    parameter int          ROW_LO   = 14,
    parameter int          NROWS    = 10,
    parameter int          ROWS_TOT = 38,
    parameter int          COLS     = 38,
    parameter logic [10:0] HDR_CODE = 11'h020
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              fiber,
    input  logic [NCH*16-1:0]        fx_ch,
    input  logic [NCH-1:0]           ch_mask,
    output logic                     out_valid,
    output logic [HDR_W-1:0]         array_header,
    output logic [ROWS_TOT*COLS-1:0] array_out,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         oor_cnt,
    output logic [CNT_W-1:0]         dup_cnt
);

    localparam int RW     = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam int CW     = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int NSUM_W = $clog2(NCH + 1);
    localparam int AW     = ROWS_TOT * COLS;

    state_e                     state_q, state_d;
    logic [7:0]                 beat_q, beat_d;
    logic [NROWS-1:0][COLS-1:0] bm_q, bm_d;
    logic [CNT_W-1:0]           hit_q, hit_d, oor_q, oor_d, dup_q, dup_d;
    logic [CNT_W-1:0]           hit_cnt_q, hit_cnt_d, oor_cnt_q, oor_cnt_d;
    logic [CNT_W-1:0]           dup_cnt_q, dup_cnt_d;
    logic                       out_valid_q, out_valid_d;
    logic [HDR_W-1:0]           hdr_q, hdr_d;
    logic [AW-1:0]              arr_q, arr_d;

    logic [NCH-1:0]             acc;
    logic [NCH-1:0]             oor;
    logic [NCH-1:0]             dup;
    logic [NCH-1:0][RW-1:0]     row_idx;
    logic [NCH-1:0][CW-1:0]     col_idx;
    logic [NSUM_W-1:0]          hit_inc, oor_inc, dup_inc;

    for (genvar k = 0; k < NCH; k++) begin : g_dec
        fiber_hit_decode #(
            .ROW_LO (ROW_LO),
            .NROWS  (NROWS),
            .COLS   (COLS),
            .RW     (RW),
            .CW     (CW)
        ) u_dec (
            .ch     (fx_ch[16*k +: 16]),
            .en     (~ch_mask[k]),
            .accept (acc[k]),
            .oor    (oor[k]),
            .row    (row_idx[k]),
            .col    (col_idx[k])
        );
    end

    // A hit is a duplicate if its bit was already set, or an earlier channel
    // in the same beat targets the same bit.
    always_comb begin
        dup = '0;
        for (int k = 0; k < NCH; k++) begin
            if (acc[k]) begin
                dup[k] = bm_q[row_idx[k]][col_idx[k]];
                for (int j = 0; j < k; j++) begin
                    if (acc[j] && row_idx[j] == row_idx[k] && col_idx[j] == col_idx[k])
                        dup[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        hit_inc = '0;
        oor_inc = '0;
        dup_inc = '0;
        for (int k = 0; k < NCH; k++) begin
            hit_inc = hit_inc + NSUM_W'(acc[k]);
            oor_inc = oor_inc + NSUM_W'(oor[k]);
            dup_inc = dup_inc + NSUM_W'(dup[k]);
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        bm_d        = bm_q;
        hit_d       = hit_q;
        oor_d       = oor_q;
        dup_d       = dup_q;
        hit_cnt_d   = hit_cnt_q;
        oor_cnt_d   = oor_cnt_q;
        dup_cnt_d   = dup_cnt_q;
        out_valid_d = 1'b0;
        hdr_d       = '0;
        arr_d       = '0;

        case (state_q)
            ST_IDLE: begin
                if (fiber == SYNC_WORD) begin
                    state_d = ST_ACC;
                    beat_d  = '0;
                end
            end
            ST_ACC: begin
                for (int k = 0; k < NCH; k++) begin
                    if (acc[k])
                        bm_d[row_idx[k]][col_idx[k]] = 1'b1;
                end
                hit_d  = sat_add(hit_q, CNT_W'(hit_inc));
                oor_d  = sat_add(oor_q, CNT_W'(oor_inc));
                dup_d  = sat_add(dup_q, CNT_W'(dup_inc));
                beat_d = beat_q + 8'd1;
                if (beat_q == 8'(NFRAME - 1))
                    state_d = ST_EMIT;
            end
            ST_EMIT: begin
                out_valid_d                         = 1'b1;
                hdr_d[HDR_FLAG_BIT]                 = 1'b1;
                hdr_d[HDR_CODE_MSB:HDR_CODE_LSB]    = HDR_CODE;
                hdr_d[HDR_TAG_MSB:HDR_TAG_LSB]      = fiber[9:0];
                hdr_d[HDR_SYNC_MSB:HDR_SYNC_LSB]    = SYNC_WORD;
                for (int r = 0; r < NROWS; r++)
                    arr_d[(ROW_LO - 1 + r)*COLS +: COLS] = bm_q[r];
                hit_cnt_d = hit_q;
                oor_cnt_d = oor_q;
                dup_cnt_d = dup_q;
                bm_d      = '0;
                hit_d     = '0;
                oor_d     = '0;
                dup_d     = '0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            bm_q        <= '0;
            hit_q       <= '0;
            oor_q       <= '0;
            dup_q       <= '0;
            hit_cnt_q   <= '0;
            oor_cnt_q   <= '0;
            dup_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            hdr_q       <= '0;
            arr_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            bm_q        <= bm_d;
            hit_q       <= hit_d;
            oor_q       <= oor_d;
            dup_q       <= dup_d;
            hit_cnt_q   <= hit_cnt_d;
            oor_cnt_q   <= oor_cnt_d;
            dup_cnt_q   <= dup_cnt_d;
            out_valid_q <= out_valid_d;
            hdr_q       <= hdr_d;
            arr_q       <= arr_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign array_header = hdr_q;
    assign array_out    = arr_q;
    assign hit_cnt      = hit_cnt_q;
    assign oor_cnt      = oor_cnt_q;
    assign dup_cnt      = dup_cnt_q;

endmodule

// File: tb/tb_fiber_hit_mapper.sv
// Self-checking bench for fiber_hit_mapper: directed and random frames checked
// against a set-of-hits reference model.
module tb_fiber_hit_mapper;

    localparam int NCH      = 16;
    localparam int NFRAME   = 16;
    localparam int ROW_LO   = 14;
    localparam int NROWS    = 10;
    localparam int ROWS_TOT = 38;
    localparam int COLS     = 38;
    localparam int AW       = ROWS_TOT * COLS;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       fiber;
    logic [NCH*16-1:0] fx_ch;
    logic [NCH-1:0]    ch_mask;
    logic              out_valid;
    logic [37:0]       array_header;
    logic [AW-1:0]     array_out;
    logic [15:0]       hit_cnt, oor_cnt, dup_cnt;

    fiber_hit_mapper dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fiber        (fiber),
        .fx_ch        (fx_ch),
        .ch_mask      (ch_mask),
        .out_valid    (out_valid),
        .array_header (array_header),
        .array_out    (array_out),
        .hit_cnt      (hit_cnt),
        .oor_cnt      (oor_cnt),
        .dup_cnt      (dup_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [NCH*16-1:0] stim      [NFRAME];
    logic [NCH-1:0]    stim_mask [NFRAME];
    bit                stim_sync [NFRAME];
    logic [9:0]        stim_tag;

    logic [AW-1:0] exp_arr;
    logic [37:0]   exp_hdr;
    int            exp_hit, exp_oor, exp_dup;

    logic          obs_valid;
    logic [AW-1:0] obs_arr;
    logic [37:0]   obs_hdr;
    logic [15:0]   obs_hit, obs_oor, obs_dup;
    int            obs_cyc, frame_len;
    bit            early_pulse;

    function automatic logic [15:0] hw(input int xm1, input int ym1);
        logic [5:0] xf, yf;
        xf = 6'(xm1);
        yf = 6'(ym1);
        return {3'b000, 1'b1, xf, yf};
    endfunction

    task automatic clear_stim();
        for (int b = 0; b < NFRAME; b++) begin
            stim[b]      = '0;
            stim_mask[b] = '0;
            stim_sync[b] = 1'b0;
        end
        stim_tag = 10'($urandom);
    endtask

    // Reference: walk every hit in beat/channel order against a plain 2-D bit
    // grid indexed by 1-based (y, x).
    task automatic model();
        bit [127:0] grid [128];
        logic [15:0] w;
        int x, y;
        for (int i = 0; i < 128; i++) grid[i] = '0;
        exp_hit = 0; exp_oor = 0; exp_dup = 0;
        for (int b = 0; b < NFRAME; b++) begin
            for (int k = 0; k < NCH; k++) begin
                w = stim[b][16*k +: 16];
                if (w[12] && !stim_mask[b][k]) begin
                    x = int'(w[11:6]) + 1;
                    y = int'(w[5:0]) + 1;
                    if (y >= ROW_LO && y <= ROW_LO + NROWS - 1 && x <= COLS - 1) begin
                        exp_hit++;
                        if (grid[y][x]) exp_dup++;
                        grid[y][x] = 1'b1;
                    end else begin
                        exp_oor++;
                    end
                end
            end
        end
        exp_arr = '0;
        for (int r = 1; r <= ROWS_TOT; r++)
            for (int c = 0; c < COLS; c++)
                exp_arr[(r-1)*COLS + c] = grid[r][c];
        exp_hdr = {1'b1, 11'h020, stim_tag, 16'hAAAA};
    endtask

    // Drives one frame on negedges; captures outputs one negedge after the
    // emit edge (sync edge + NFRAME + 1).
    task automatic drive_frame(input bit sync_now, input bit sync_after);
        model();
        if (sync_now) begin
            @(negedge clk);
            fiber = 16'hAAAA; fx_ch = '0; ch_mask = '0;
        end
        early_pulse = 1'b0;
        for (int b = 0; b < NFRAME; b++) begin
            @(negedge clk);
            if (b == 0) frame_len = cyc;
            if (out_valid) early_pulse = 1'b1;
            fiber   = stim_sync[b] ? 16'hAAAA : 16'h1234;
            fx_ch   = stim[b];
            ch_mask = stim_mask[b];
        end
        @(negedge clk);
        if (out_valid) early_pulse = 1'b1;
        fiber = {6'($urandom), stim_tag};
        for (int k = 0; k < NCH; k++) fx_ch[16*k +: 16] = 16'($urandom);
        ch_mask = '0;
        @(negedge clk);
        obs_valid = out_valid; obs_arr = array_out; obs_hdr = array_header;
        obs_hit = hit_cnt; obs_oor = oor_cnt; obs_dup = dup_cnt;
        obs_cyc = cyc;
        frame_len = cyc - frame_len;
        fiber = sync_after ? 16'hAAAA : 16'h0000;
        fx_ch = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fiber = '0; fx_ch = '0; ch_mask = '0;
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (array_out !== '0) begin errors++; $display("FAIL reset_array: got %h want 0", array_out); end
        checks++; if (array_header !== '0) begin errors++; $display("FAIL reset_header: got %h want 0", array_header); end
        checks++; if ({hit_cnt, oor_cnt, dup_cnt} !== 48'd0) begin errors++; $display("FAIL reset_cnts: got %h %h %h want 0", hit_cnt, oor_cnt, dup_cnt); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_single_hit();
        clear_stim();
        stim[0][15:0] = hw(4, 13);
        drive_frame(1'b1, 1'b0);
        checks++; if (early_pulse !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", early_pulse); end
        checks++; if (obs_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", obs_valid); end
        checks++; if (obs_arr[13*COLS + 5] !== 1'b1) begin errors++; $display("FAIL single_bit_r14c5: got %b want 1", obs_arr[13*COLS + 5]); end
        checks++; if (obs_arr !== exp_arr) begin errors++; $display("FAIL single_array: got %h want %h", obs_arr, exp_arr); end
        checks++; if (obs_hdr !== exp_hdr) begin errors++; $display("FAIL single_header: got %h want %h", obs_hdr, exp_hdr); end
        checks++; if (obs_hit !== 16'(exp_hit) || exp_hit != 1) begin errors++; $display("FAIL single_hit_cnt: got %0d want 1", obs_hit); end
        checks++; if (frame_len !== NFRAME + 1) begin errors++; $display("FAIL single_latency: got %0d want %0d", frame_len, NFRAME + 1); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", out_valid); end
        checks++; if (array_out !== '0 || array_header !== '0) begin errors++; $display("FAIL single_zero_after: got %h / %h want 0", array_header, array_out); end
        checks++; if (hit_cnt !== 16'd1) begin errors++; $display("FAIL single_cnt_hold: got %0d want 1", hit_cnt); end
    endtask

    task automatic test_oor();
        clear_stim();
        stim[0][16*3 +: 16] = hw(4, 12);
        stim[0][16*4 +: 16] = hw(4, 23);
        stim[0][16*5 +: 16] = hw(40, 15);
        drive_frame(1'b1, 1'b0);
        checks++; if (obs_arr !== '0) begin errors++; $display("FAIL oor_array: got %h want 0", obs_arr); end
        checks++; if (obs_oor !== 16'd3) begin errors++; $display("FAIL oor_cnt: got %0d want 3", obs_oor); end
        checks++; if (obs_hit !== 16'd0) begin errors++; $display("FAIL oor_hit_cnt: got %0d want 0", obs_hit); end
    endtask

    task automatic test_boundary();
        clear_stim();
        stim[0][16*0 +: 16] = hw(36, 13);
        stim[0][16*1 +: 16] = hw(0, 22);
        stim[0][16*2 +: 16] = hw(37, 15);
        stim[0][16*3 +: 16] = hw(63, 15);
        stim[0][16*4 +: 16] = hw(5, 63);
        drive_frame(1'b1, 1'b0);
        checks++; if (obs_arr !== exp_arr) begin errors++; $display("FAIL bound_array: got %h want %h", obs_arr, exp_arr); end
        checks++; if (obs_arr[13*COLS + 37] !== 1'b1 || obs_arr[22*COLS + 1] !== 1'b1) begin errors++; $display("FAIL bound_edges: got %b%b want 11", obs_arr[13*COLS + 37], obs_arr[22*COLS + 1]); end
        checks++; if (obs_hit !== 16'd2 || obs_oor !== 16'd3) begin errors++; $display("FAIL bound_cnts: got hit %0d oor %0d want 2 3", obs_hit, obs_oor); end
    endtask

    task automatic test_dup();
        clear_stim();
        stim[0][16*0 +: 16] = hw(9, 19);
        stim[0][16*7 +: 16] = hw(9, 19);
        stim[4][16*2 +: 16] = hw(9, 19);
        drive_frame(1'b1, 1'b0);
        checks++; if (obs_arr[19*COLS + 10] !== 1'b1) begin errors++; $display("FAIL dup_bit_r20c10: got %b want 1", obs_arr[19*COLS + 10]); end
        checks++; if (obs_arr !== exp_arr) begin errors++; $display("FAIL dup_array: got %h want %h", obs_arr, exp_arr); end
        checks++; if (obs_hit !== 16'd3) begin errors++; $display("FAIL dup_hit_cnt: got %0d want 3", obs_hit); end
        checks++; if (obs_dup !== 16'd2) begin errors++; $display("FAIL dup_cnt: got %0d want 2", obs_dup); end
    endtask

    task automatic test_mask_sync();
        clear_stim();
        for (int b = 0; b < NFRAME; b++) stim_mask[b] = 16'h0001;
        stim[0][15:0] = hw(4, 13);
        stim[6][15:0] = hw(8, 16);
        stim_sync[2] = 1'b1; stim_sync[9] = 1'b1; stim_sync[NFRAME-1] = 1'b1;
        drive_frame(1'b1, 1'b0);
        checks++; if (obs_arr !== '0) begin errors++; $display("FAIL mask_array: got %h want 0", obs_arr); end
        checks++; if (obs_hit !== 16'd0) begin errors++; $display("FAIL mask_hit_cnt: got %0d want 0", obs_hit); end
        checks++; if (obs_valid !== 1'b1 || early_pulse !== 1'b0) begin errors++; $display("FAIL mask_no_restart: got valid %b early %b want 1 0", obs_valid, early_pulse); end
    endtask

    task automatic test_back_to_back();
        int first_cyc;
        logic [AW-1:0] first_arr;
        clear_stim();
        stim[1][16*2 +: 16] = hw(3, 14);
        stim[3][16*9 +: 16] = hw(20, 18);
        drive_frame(1'b1, 1'b1);
        first_cyc = obs_cyc;
        first_arr = obs_arr;
        checks++; if (obs_valid !== 1'b1 || first_arr !== exp_arr) begin errors++; $display("FAIL b2b_first: got %b %h want 1 %h", obs_valid, first_arr, exp_arr); end
        clear_stim();
        stim[2][16*4 +: 16] = hw(11, 21);
        drive_frame(1'b0, 1'b0);
        checks++; if (early_pulse !== 1'b0 || obs_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got early %b valid %b want 0 1", early_pulse, obs_valid); end
        checks++; if (obs_cyc - first_cyc !== NFRAME + 2) begin errors++; $display("FAIL b2b_spacing: got %0d want %0d", obs_cyc - first_cyc, NFRAME + 2); end
        checks++; if (obs_arr !== exp_arr) begin errors++; $display("FAIL b2b_second_array: got %h want %h", obs_arr, exp_arr); end
        checks++; if (obs_hit !== 16'(exp_hit)) begin errors++; $display("FAIL b2b_second_hit: got %0d want %0d", obs_hit, exp_hit); end
    endtask

    task automatic test_reset_mid();
        bit pulse;
        clear_stim();
        for (int b = 0; b < NFRAME; b++) stim[b][16*(b % NCH) +: 16] = hw(b + 2, 13 + (b % NROWS));
        @(negedge clk);
        fiber = 16'hAAAA; fx_ch = '0; ch_mask = '0;
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            fiber = 16'h0; fx_ch = stim[b];
        end
        @(negedge clk);
        rst_n = 1'b0; fx_ch = '0;
        #1;
        checks++; if ({hit_cnt, oor_cnt, dup_cnt} !== 48'd0) begin errors++; $display("FAIL rstmid_cnts: got %h %h %h want 0", hit_cnt, oor_cnt, dup_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        pulse = 1'b0;
        repeat (NFRAME + 4) begin
            @(negedge clk);
            if (out_valid) pulse = 1'b1;
        end
        checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: got pulse %b want 0", pulse); end
        clear_stim();
        stim[5][16*6 +: 16] = hw(30, 20);
        drive_frame(1'b1, 1'b0);
        checks++; if (obs_arr !== exp_arr) begin errors++; $display("FAIL rstmid_next_array: got %h want %h", obs_arr, exp_arr); end
        checks++; if (obs_hit !== 16'd1) begin errors++; $display("FAIL rstmid_next_hit: got %0d want 1", obs_hit); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 12; n++) begin
            clear_stim();
            for (int b = 0; b < NFRAME; b++) begin
                for (int k = 0; k < NCH; k++) begin
                    if ($urandom_range(0, 3) == 0)
                        stim[b][16*k +: 16] = {3'($urandom), 1'b1,
                                               6'($urandom_range(0, 40)), 6'($urandom_range(10, 25))};
                    else
                        stim[b][16*k +: 16] = {3'($urandom), 1'b0, 12'($urandom)};
                end
                stim_mask[b] = 16'($urandom) & 16'($urandom) & 16'($urandom);
                stim_sync[b] = ($urandom_range(0, 7) == 0);
            end
            drive_frame(1'b1, 1'b0);
            checks++; if (obs_valid !== 1'b1 || early_pulse !== 1'b0) begin errors++; $display("FAIL rand%0d_valid: got %b early %b want 1 0", n, obs_valid, early_pulse); end
            checks++; if (obs_arr !== exp_arr) begin errors++; $display("FAIL rand%0d_array: got %h want %h", n, obs_arr, exp_arr); end
            checks++; if (obs_hdr !== exp_hdr) begin errors++; $display("FAIL rand%0d_header: got %h want %h", n, obs_hdr, exp_hdr); end
            checks++; if (obs_hit !== 16'(exp_hit)) begin errors++; $display("FAIL rand%0d_hit: got %0d want %0d", n, obs_hit, exp_hit); end
            checks++; if (obs_oor !== 16'(exp_oor)) begin errors++; $display("FAIL rand%0d_oor: got %0d want %0d", n, obs_oor, exp_oor); end
            checks++; if (obs_dup !== 16'(exp_dup)) begin errors++; $display("FAIL rand%0d_dup: got %0d want %0d", n, obs_dup, exp_dup); end
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_oor();
        test_boundary();
        test_dup();
        test_mask_sync();
        test_back_to_back();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
